// File: rtl/spi_regmem_slave.sv
// ---------------------------------------------------------------------------
// spi_regmem_slave
//   SPI mode-0 slave giving a host burst read/write access to an on-chip
//   DEPTH x DATA_W memory, plus a system-side read port and a write strobe.
//   Everything runs on clk: the SPI pins are synchronised and edge-detected,
//   spi_clk is only ever treated as data.
//
//   Frame: CS low, 8-bit command (0x02 write / 0x03 read / else discard),
//   ADDR_W-bit address, then DATA_W-bit words with an auto-incrementing
//   pointer that wraps modulo DEPTH.
//
// Ports
//   clk             system clock (spi_clk must be <= clk/8)
//   global_reset_n  asynchronous active-low reset
//   spi_clk/spi_cs/spi_si  SPI inputs (CPOL=0, CS active low)
//   spi_so          MISO
//   wr_strobe       1-cycle pulse per word written by the host
//   wr_addr/wr_data address/data of that word, valid with wr_strobe
//   sys_raddr       system read address
//   sys_rdata       mem[sys_raddr], 1-cycle latency (0 if out of range)
//   busy            a frame is in progress
//   frame_err       1-cycle pulse: CS rose inside a partial cmd/addr/word
// ---------------------------------------------------------------------------
module spi_regmem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              global_reset_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_si,
  output logic              spi_so,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] sys_raddr,
  output logic [DATA_W-1:0] sys_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAXW0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAXW  = (MAXW0 > 8) ? MAXW0 : 8;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_FETCH, S_RDATA, S_DISCARD
  } state_t;

  state_t state_q, state_d;

  // ---------------- pin synchronisers + edge detect ----------------
  // CS sync resets low: if CS is held low across a reset no falling edge is
  // seen, so a new frame needs CS to go high and fall again.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, si_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, si_s;
  logic                   cs_edge, cs_fall, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      si_sync   <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      si_sync   <= {si_sync[SYNC_STAGES-2:0], spi_si};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign si_s      = si_sync[SYNC_STAGES-1];
  assign cs_edge   = cs_s ^ cs_q;
  assign cs_fall   = cs_q & ~cs_s;
  // A CS edge in the same cycle masks any spi_clk edge.
  assign sclk_rise = ~sclk_q & sclk_s & ~cs_edge;
  assign sclk_fall = sclk_q & ~sclk_s & ~cs_edge;

  // ---------------- datapath state ----------------
  logic [CW-1:0]     cnt;      // bits received in current cmd/addr/word
  logic [CW-1:0]     ocnt;     // bits driven in current read word
  logic [MAXW-2:0]   shin;
  logic [MAXW-1:0]   in_word;
  logic [DATA_W-1:0] oshr;
  logic [ADDR_W-1:0] ptr, ptr_inc, addr_mod;
  logic              rd_mode, pf_q;
  logic [CW-1:0]     lim;
  logic              last;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_word  = {shin, si_s};
  assign ptr_inc  = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign addr_mod = ADDR_W'({1'b0, in_word[ADDR_W-1:0]} % DEPTH_L);

  always_comb begin
    case (state_q)
      S_CMD:   lim = CW'(7);
      S_ADDR:  lim = CW'(ADDR_W - 1);
      default: lim = CW'(DATA_W - 1);
    endcase
  end
  assign last = (cnt == lim);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD:
          if (sclk_rise && last)
            state_d = (in_word[7:0] == 8'h02 || in_word[7:0] == 8'h03) ? S_ADDR : S_DISCARD;
        S_ADDR:  if (sclk_rise && last) state_d = rd_mode ? S_FETCH : S_WDATA;
        S_FETCH: state_d = S_RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- FSM: decoded controls ----------------
  logic abort, start, shift_en, cmd_done, addr_done, wr_word;
  logic load_o, so_fall, pf, ferr;

  always_comb begin
    busy      = (state_q != S_IDLE);
    abort     = busy && cs_s;
    start     = (state_q == S_IDLE) && cs_fall;
    shift_en  = !abort && sclk_rise &&
                (state_q inside {S_CMD, S_ADDR, S_WDATA, S_RDATA});
    cmd_done  = shift_en && last && (state_q == S_CMD);
    addr_done = shift_en && last && (state_q == S_ADDR);
    wr_word   = shift_en && last && (state_q == S_WDATA);
    load_o    = !abort && (state_q == S_FETCH);
    so_fall   = !abort && sclk_fall && (state_q == S_RDATA);
    // LSB just driven: advance pointer, reload shifter next cycle
    pf        = so_fall && (ocnt == CW'(DATA_W - 1));
    ferr      = abort && (cnt != '0);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      cnt       <= '0;
      ocnt      <= '0;
      shin      <= '0;
      oshr      <= '0;
      ptr       <= '0;
      rd_mode   <= 1'b0;
      pf_q      <= 1'b0;
      spi_so    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      sys_rdata <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= wr_word;
      frame_err <= ferr;
      pf_q      <= pf;
      // Reads see the pre-write contents when colliding with a host write.
      sys_rdata <= ({1'b0, sys_raddr} < DEPTH_L) ? mem[sys_raddr[MW-1:0]] : '0;

      if (start || abort)  cnt <= '0;
      else if (shift_en)   cnt <= last ? '0 : cnt + 1'b1;

      if (shift_en) shin <= in_word[MAXW-2:0];
      if (cmd_done) rd_mode <= (in_word[7:0] == 8'h03);

      if (addr_done)          ptr <= addr_mod;
      else if (wr_word || pf) ptr <= ptr_inc;

      if (wr_word) begin
        wr_addr <= ptr;
        wr_data <= in_word[DATA_W-1:0];
      end

      if (load_o || pf_q) begin
        oshr <= mem[ptr[MW-1:0]];
        if (load_o) ocnt <= '0;
      end else if (so_fall) begin
        oshr <= {oshr[DATA_W-2:0], 1'b0};
        ocnt <= pf ? '0 : ocnt + 1'b1;
      end

      if (state_q == S_RDATA && !abort) begin
        if (so_fall) spi_so <= oshr[DATA_W-1];
      end else begin
        spi_so <= 1'b0;
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_word) mem[ptr[MW-1:0]] <= in_word[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_regmem_slave.sv
// Testbench for spi_regmem_slave: one instance with default parameters and
// one with DATA_W=16, ADDR_W=10, DEPTH=600, sharing spi_clk/spi_si, each with
// its own chip select. Expected memory contents, write strobes and frame
// error counts come from a plain array model of the memory map.
module tb_spi_regmem_slave;
  localparam int HALF = 8;  // clk cycles per SPI half period

  logic       clk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, spi_si = 1'b0;
  logic [1:0] cs = 2'b11;
  always #5 clk = ~clk;

  logic        so0, ws0, busy0, fe0;
  logic [7:0]  wa0, wd0, rd0;
  logic [7:0]  ra0 = '0;
  logic        so1, ws1, busy1, fe1;
  logic [9:0]  wa1, ra1 = '0;
  logic [15:0] wd1, rd1;

  spi_regmem_slave u0 (
    .clk(clk), .global_reset_n(rst_n), .spi_clk(spi_clk), .spi_cs(cs[0]),
    .spi_si(spi_si), .spi_so(so0), .wr_strobe(ws0), .wr_addr(wa0),
    .wr_data(wd0), .sys_raddr(ra0), .sys_rdata(rd0), .busy(busy0),
    .frame_err(fe0));

  spi_regmem_slave #(.DATA_W(16), .ADDR_W(10), .DEPTH(600), .SYNC_STAGES(2)) u1 (
    .clk(clk), .global_reset_n(rst_n), .spi_clk(spi_clk), .spi_cs(cs[1]),
    .spi_si(spi_si), .spi_so(so1), .wr_strobe(ws1), .wr_addr(wa1),
    .wr_data(wd1), .sys_raddr(ra1), .sys_rdata(rd1), .busy(busy1),
    .frame_err(fe1));

  int tests = 0, fails = 0;
  int ferr_cnt [2] = '{0, 0};
  int exp_ferr [2] = '{0, 0};
  logic [31:0] got0[$], got1[$], exp_q[$];
  logic [15:0] wq[$];
  logic [15:0] mm [2][1024];
  bit          kn [2][1024];

  // Capture every strobe / error pulse away from the active edge.
  always @(negedge clk) begin
    if (ws0) got0.push_back({16'(wa0), 16'(wd0)});
    if (ws1) got1.push_back({6'd0, wa1, wd1});
    if (fe0) ferr_cnt[0]++;
    if (fe1) ferr_cnt[1]++;
  end

  function automatic int aw(input int d);  return d ? 10 : 8;     endfunction
  function automatic int dw(input int d);  return d ? 16 : 8;     endfunction
  function automatic int dep(input int d); return d ? 600 : 256;  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input int dev, input logic b, output logic so);
    spi_si = b;
    repeat (HALF) @(negedge clk);
    so = (dev == 0) ? so0 : so1;   // MISO must be valid at the rising edge
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send(input int dev, input int n, input logic [31:0] v, output logic [31:0] r);
    logic s;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(dev, v[i], s);
      r[i] = s;
    end
  endtask

  task automatic cs_low(input int dev);
    cs[dev] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high(input int dev);
    repeat (HALF) @(negedge clk);
    cs[dev] = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic check_strobes(input int dev, input string tag);
    logic [31:0] g;
    check({tag, "_nstrobe"}, (dev == 0) ? got0.size() : got1.size(), exp_q.size());
    check({tag, "_other_nstrobe"}, (dev == 0) ? got1.size() : got0.size(), 0);
    foreach (exp_q[i]) begin
      if (dev == 0) g = (i < got0.size()) ? got0[i] : '1;
      else          g = (i < got1.size()) ? got1[i] : '1;
      check({tag, "_strobe"}, g, exp_q[i]);
    end
    got0.delete(); got1.delete(); exp_q.delete();
  endtask

  // Write frame with the words in wq, optionally followed by a partial word.
  task automatic do_write(input int dev, input int addr, input int partial, input string tag);
    logic [31:0] r;
    logic [15:0] w;
    int p;
    cs_low(dev);
    send(dev, 8, 32'h02, r);
    send(dev, aw(dev), addr, r);
    p = addr % dep(dev);
    foreach (wq[i]) begin
      w = (dev == 0) ? (wq[i] & 16'h00FF) : wq[i];
      send(dev, dw(dev), 32'(w), r);
      mm[dev][p] = w;
      kn[dev][p] = 1'b1;
      exp_q.push_back({16'(p), w});
      p = (p + 1) % dep(dev);
    end
    if (partial > 0) begin
      send(dev, partial, $urandom, r);
      exp_ferr[dev]++;
    end
    cs_high(dev);
    check_strobes(dev, tag);
    check({tag, "_ferr"}, ferr_cnt[dev], exp_ferr[dev]);
  endtask

  task automatic do_read(input int dev, input int addr, input int nw, input string tag);
    logic [31:0] r;
    int p;
    cs_low(dev);
    send(dev, 8, 32'h03, r);
    send(dev, aw(dev), addr, r);
    p = addr % dep(dev);
    for (int k = 0; k < nw; k++) begin
      send(dev, dw(dev), $urandom, r);
      if (kn[dev][p]) check(tag, r, 32'(mm[dev][p]));
      p = (p + 1) % dep(dev);
    end
    cs_high(dev);
    check_strobes(dev, {tag, "_nowr"});
  endtask

  task automatic sys_check(input int dev, input int addr, input string tag);
    if (dev == 0) ra0 = 8'(addr); else ra1 = 10'(addr);
    @(negedge clk);
    check(tag, (dev == 0) ? 32'(rd0) : 32'(rd1), 32'(mm[dev][addr]));
  endtask

  initial begin
    logic [31:0] r;
    int dev, addr, n, part;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    check("rst_so", so0, 0);      check("rst_ws", ws0, 0);
    check("rst_wa", wa0, 0);      check("rst_wd", wd0, 0);
    check("rst_rd", rd0, 0);      check("rst_busy", busy0, 0);
    check("rst_fe", fe0, 0);      check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // ---- write burst ----
    wq = '{16'hA5, 16'h3C};
    do_write(0, 'h10, 0, "t1_wr");
    sys_check(0, 'h11, "t1_sys");

    // ---- read burst ----
    do_read(0, 'h10, 2, "t2_rd");

    // ---- wrap at top of memory ----
    wq = '{16'($urandom), 16'($urandom)};
    do_write(0, 'hFF, 0, "t3_wr");
    do_read(0, 'hFF, 2, "t3_rd");
    sys_check(0, 'h00, "t3_sys");

    // ---- aborted word, bad command ----
    wq = '{16'h5A};
    do_write(0, 'h20, 0, "t4_pre");
    wq = {};
    do_write(0, 'h20, 5, "t4_abort");
    sys_check(0, 'h20, "t4_sys");
    cs_low(0);
    send(0, 8, 32'h55, r);
    send(0, 16, $urandom, r);
    check("t4_bad_so", r, 0);
    cs_high(0);
    check_strobes(0, "t4_bad");
    check("t4_bad_ferr", ferr_cnt[0], exp_ferr[0]);

    // ---- reset mid-word ----
    wq = '{16'hC3};
    do_write(0, 'h37, 0, "t5_pre");
    ra0 = 8'h37;
    cs_low(0);
    send(0, 8, 32'h02, r);
    send(0, 8, 32'h40, r);
    send(0, 3, 32'h5, r);
    check("t5_busy", busy0, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_so", so0, 0);     check("t5_ws", ws0, 0);
    check("t5_wa", wa0, 0);     check("t5_wd", wd0, 0);
    check("t5_rd", rd0, 0);     check("t5_busy_rst", busy0, 0);
    check("t5_fe", fe0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 16, 32'hFFFF, r);
    check("t5_busy_ign", busy0, 0);
    cs_high(0);
    check_strobes(0, "t5_ign");
    check("t5_ferr", ferr_cnt[0], exp_ferr[0]);
    wq = '{16'($urandom)};
    do_write(0, 'h41, 0, "t5_post");
    do_read(0, 'h41, 1, "t5_post_rd");

    // ---- wide instance, wrap at DEPTH=600 ----
    wq = '{16'($urandom), 16'($urandom)};
    do_write(1, 599, 0, "t6_wr");
    do_read(1, 599, 2, "t6_rd");
    sys_check(1, 0, "t6_sys");

    // ---- randomized frames ----
    for (int it = 0; it < 10; it++) begin
      dev  = int'($urandom_range(0, 1));
      addr = int'($urandom_range(0, (1 << aw(dev)) - 1));
      n    = int'($urandom_range(1, 3));
      part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dw(dev) - 1)) : 0;
      wq = {};
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
      do_write(dev, addr, part, "rnd_wr");
      do_read(dev, addr, n + 1, "rnd_rd");
      sys_check(dev, addr % dep(dev), "rnd_sys");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
